// File: rtl/algo_2rw_a54_t1_bank_model.sv
// Behavioural 1W/1R SRAM bank set answering the t1 physical-bank requests of the 2rw_a54 core.
// Rewrites every row with INITVAL after reset, then serves masked writes and pipelined reads.
module algo_2rw_a54_t1_bank_model #(
  parameter int                 NUMPBNK    = 4,
  parameter int                 NUMSROW    = 2048,
  parameter int                 BITSROW    = 11,
  parameter int                 PHYWDTH    = 73,
  parameter int                 SRAM_DELAY = 1,
  parameter logic [PHYWDTH-1:0] INITVAL    = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ready,
  input  logic [NUMPBNK-1:0]           t1_writeA,
  input  logic [NUMPBNK*BITSROW-1:0]   t1_addrA,
  input  logic [NUMPBNK*PHYWDTH-1:0]   t1_dinA,
  input  logic [NUMPBNK*PHYWDTH-1:0]   t1_bwA,
  input  logic [NUMPBNK-1:0]           t1_readB,
  input  logic [NUMPBNK*BITSROW-1:0]   t1_addrB,
  output logic [NUMPBNK*PHYWDTH-1:0]   t1_doutB,
  output logic [NUMPBNK-1:0]           t1_collB,
  output logic [NUMPBNK-1:0]           t1_errA
);

  typedef enum logic [0:0] {INIT, RDY} state_t;

  state_t             state_reg;
  logic [BITSROW-1:0] icnt_reg;
  logic               ready_reg;
  logic               init_we;
  logic               in_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= INIT;
      icnt_reg  <= '0;
      ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          icnt_reg <= icnt_reg + 1'b1;
          if (int'(icnt_reg) == NUMSROW - 1) begin
            state_reg <= RDY;
            ready_reg <= 1'b1;
          end
        end
        default: ready_reg <= 1'b1;
      endcase
    end
  end

  assign ready   = ready_reg;
  assign init_we = (state_reg == INIT);
  assign in_rdy  = (state_reg == RDY);

  for (genvar gi = 0; gi < NUMPBNK; gi++) begin : g_bank
    logic [BITSROW-1:0]    addr_a;
    logic [BITSROW-1:0]    addr_b;
    logic [PHYWDTH-1:0]    din_a;
    logic [PHYWDTH-1:0]    bw_a;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  coll_now;
    logic                  err_set;
    logic [PHYWDTH-1:0]    mem [NUMSROW];
    logic [PHYWDTH-1:0]    rd_q;
    logic [PHYWDTH-1:0]    tail_data;
    logic [SRAM_DELAY-1:0] vld_reg;
    logic [SRAM_DELAY-1:0] coll_reg;
    logic [PHYWDTH-1:0]    dout_reg;
    logic                  collb_reg;
    logic                  err_reg;

    assign addr_a      = t1_addrA[gi*BITSROW +: BITSROW];
    assign addr_b      = t1_addrB[gi*BITSROW +: BITSROW];
    assign din_a       = t1_dinA[gi*PHYWDTH +: PHYWDTH];
    assign bw_a        = t1_bwA[gi*PHYWDTH +: PHYWDTH];
    assign wr_in_range = int'(addr_a) < NUMSROW;
    assign rd_in_range = int'(addr_b) < NUMSROW;
    assign wr_ok       = in_rdy & t1_writeA[gi] & wr_in_range;
    assign rd_ok       = in_rdy & t1_readB[gi] & rd_in_range;
    assign coll_now    = rd_ok & wr_ok & (addr_a == addr_b);
    // Before ready any request is illegal; afterwards only out-of-range rows are.
    assign err_set     = in_rdy ? ((t1_writeA[gi] & ~wr_in_range) | (t1_readB[gi] & ~rd_in_range))
                                : (t1_writeA[gi] | t1_readB[gi]);

    // Array port: non-blocking semantics give read-before-write on a same-row collision.
    always_ff @(posedge clk) begin
      if (init_we) begin
        mem[icnt_reg] <= INITVAL;
      end else if (wr_ok) begin
        mem[addr_a] <= (mem[addr_a] & ~bw_a) | (din_a & bw_a);
      end
      if (rd_ok) begin
        rd_q <= mem[addr_b];
      end
    end

    if (SRAM_DELAY == 1) begin : g_d1
      assign tail_data = rd_q;
    end else begin : g_dn
      logic [PHYWDTH-1:0] data_reg [SRAM_DELAY-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < SRAM_DELAY - 1; k++) begin
            data_reg[k] <= '0;
          end
        end else begin
          data_reg[0] <= rd_q;
          for (int k = 1; k < SRAM_DELAY - 1; k++) begin
            data_reg[k] <= data_reg[k-1];
          end
        end
      end

      assign tail_data = data_reg[SRAM_DELAY-2];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_reg   <= '0;
        coll_reg  <= '0;
        dout_reg  <= '0;
        collb_reg <= 1'b0;
        err_reg   <= 1'b0;
      end else begin
        vld_reg[0]  <= rd_ok;
        coll_reg[0] <= coll_now;
        for (int k = 1; k < SRAM_DELAY; k++) begin
          vld_reg[k]  <= vld_reg[k-1];
          coll_reg[k] <= coll_reg[k-1];
        end
        // Output register: data holds between completions, coll pulses only on one.
        if (vld_reg[SRAM_DELAY-1]) begin
          dout_reg  <= tail_data;
          collb_reg <= coll_reg[SRAM_DELAY-1];
        end else begin
          collb_reg <= 1'b0;
        end
        if (err_set) begin
          err_reg <= 1'b1;
        end
      end
    end

    assign t1_doutB[gi*PHYWDTH +: PHYWDTH] = dout_reg;
    assign t1_collB[gi]                    = collb_reg;
    assign t1_errA[gi]                     = err_reg;
  end

endmodule

// File: tb/tb_algo_2rw_a54_t1_bank_model.sv
// Bench for algo_2rw_a54_t1_bank_model: a delivery-queue model checked every cycle,
// plus directed transactions with hand-computed expectations.
`timescale 1ns/1ps
module tb_algo_2rw_a54_t1_bank_model;
  localparam int NB = 4;
  localparam int NR = 2000;
  localparam int BR = 11;
  localparam int W  = 73;
  localparam int D  = 3;
  localparam int CW = NB * W;
  localparam logic [W-1:0] IV   = 73'h1_2345_6789_ABCD_EF01_23;
  localparam logic [W-1:0] ONES = '1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ready;
  logic [NB-1:0]    t1_writeA;
  logic [NB*BR-1:0] t1_addrA;
  logic [CW-1:0]    t1_dinA;
  logic [CW-1:0]    t1_bwA;
  logic [NB-1:0]    t1_readB;
  logic [NB*BR-1:0] t1_addrB;
  logic [CW-1:0]    t1_doutB;
  logic [NB-1:0]    t1_collB;
  logic [NB-1:0]    t1_errA;

  algo_2rw_a54_t1_bank_model #(
    .NUMPBNK(NB), .NUMSROW(NR), .BITSROW(BR), .PHYWDTH(W), .SRAM_DELAY(D), .INITVAL(IV)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .t1_writeA(t1_writeA), .t1_addrA(t1_addrA), .t1_dinA(t1_dinA), .t1_bwA(t1_bwA),
    .t1_readB(t1_readB), .t1_addrB(t1_addrB),
    .t1_doutB(t1_doutB), .t1_collB(t1_collB), .t1_errA(t1_errA)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: array contents, expected outputs, and a queue of reads due to complete.
  typedef struct {
    int           due;
    int           bank;
    logic [W-1:0] data;
    bit           coll;
  } pend_t;

  logic [W-1:0]  mem_m [NB][NR];
  logic          exp_ready;
  logic [CW-1:0] exp_dout;
  logic [NB-1:0] exp_coll;
  logic [NB-1:0] exp_err;
  int            edges;
  int            ecount = 0;
  pend_t         pq[$];

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] dslice(input int b);
    return t1_doutB[b*W +: W];
  endfunction

  function automatic logic [W-1:0] pat(input int b);
    return W'((b + 1) * 32'h0101_0101);
  endfunction

  task automatic model_reset();
    exp_ready = 1'b0;
    exp_dout  = '0;
    exp_coll  = '0;
    exp_err   = '0;
    edges     = 0;
    pq.delete();
  endtask

  // Applies the rules of one clock edge to the model using the inputs presented to it.
  task automatic model_edge();
    logic  was_ready;
    int    ra;
    int    wa;
    pend_t p;
    logic [W-1:0] din;
    logic [W-1:0] bw;
    if (rst) return;
    ecount++;
    edges++;
    was_ready = exp_ready;
    exp_coll  = '0;
    for (int b = 0; b < NB; b++) begin
      ra  = int'(t1_addrB[b*BR +: BR]);
      wa  = int'(t1_addrA[b*BR +: BR]);
      din = t1_dinA[b*W +: W];
      bw  = t1_bwA[b*W +: W];
      if (!was_ready) begin
        if (t1_readB[b] || t1_writeA[b]) exp_err[b] = 1'b1;
      end else begin
        if ((t1_readB[b] && ra >= NR) || (t1_writeA[b] && wa >= NR)) exp_err[b] = 1'b1;
        if (t1_readB[b] && ra < NR) begin
          p.due  = ecount + D;
          p.bank = b;
          p.data = mem_m[b][ra];
          p.coll = t1_writeA[b] && (wa == ra);
          pq.push_back(p);
        end
        if (t1_writeA[b] && wa < NR) mem_m[b][wa] = (mem_m[b][wa] & ~bw) | (din & bw);
      end
    end
    while (pq.size() > 0 && pq[0].due == ecount) begin
      exp_dout[pq[0].bank*W +: W] = pq[0].data;
      exp_coll[pq[0].bank]        = pq[0].coll;
      void'(pq.pop_front());
    end
    if (!was_ready && edges == NR) begin
      exp_ready = 1'b1;
      for (int b = 0; b < NB; b++)
        for (int r = 0; r < NR; r++) mem_m[b][r] = IV;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", CW'(ready), CW'(exp_ready));
      chk("doutB", t1_doutB, exp_dout);
      chk("collB", CW'(t1_collB), CW'(exp_coll));
      chk("errA", CW'(t1_errA), CW'(exp_err));
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic clear();
    t1_writeA = '0; t1_addrA = '0; t1_dinA = '0; t1_bwA = '0;
    t1_readB  = '0; t1_addrB = '0;
  endtask

  task automatic set_wr(input int b, input int row, input logic [W-1:0] d, input logic [W-1:0] m);
    t1_writeA[b]          = 1'b1;
    t1_addrA[b*BR +: BR]  = BR'(row);
    t1_dinA[b*W +: W]     = d;
    t1_bwA[b*W +: W]      = m;
  endtask

  task automatic set_rd(input int b, input int row);
    t1_readB[b]           = 1'b1;
    t1_addrB[b*BR +: BR]  = BR'(row);
  endtask

  task automatic drain();
    clear();
    for (int i = 0; i < D; i++) step();
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < NR + 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    clear();
    #1;
    assert_rst();
    chk_en = 1'b1;
    chk("rst_ready", CW'(ready), CW'(1'b0));
    chk("rst_dout", t1_doutB, '0);
    step(); step();
    rst = 1'b0;

    // Init phase with one illegal read on bank 3.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) set_rd(3, 0);
      step();
      clear();
      if (i == 0) chk("init_ready_low", CW'(ready), CW'(1'b0));
      if (i == 2) chk("init_err3", CW'(t1_errA), CW'(4'b1000));
    end
    wait_ready(n);
    $display("init done after %0d cycles", n + 5);
    chk("init_len", CW'(n + 5), CW'(NR));

    set_rd(0, NR - 1); set_rd(1, 0);
    step(); drain();
    $display("rd b0 r%0d -> %h, b1 r0 -> %h", NR - 1, dslice(0), dslice(1));
    chk("init_val_b0", CW'(dslice(0)), CW'(IV));
    chk("init_val_b1", CW'(dslice(1)), CW'(IV));

    set_wr(2, 5, ONES, ONES); step(); clear();
    set_rd(2, 5); step(); drain();
    $display("wr/rd b2 r5 -> %h coll=%b", dslice(2), t1_collB[2]);
    chk("b2_ones", CW'(dslice(2)), CW'(ONES));
    chk("b2_nocoll", CW'(t1_collB[2]), CW'(1'b0));

    set_wr(1, 7, '0, ONES); step(); clear();
    set_wr(1, 7, ONES, W'(4'hF)); step(); clear();
    set_rd(1, 7); step(); drain();
    $display("masked b1 r7 -> %h", dslice(1));
    chk("masked", CW'(dslice(1)), CW'(W'(4'hF)));

    set_wr(0, 3, W'(8'hAA), ONES); set_rd(0, 3); step(); drain();
    $display("coll b0 r3 -> %h coll=%b", dslice(0), t1_collB[0]);
    chk("coll_old", CW'(dslice(0)), CW'(IV));
    chk("coll_flag", CW'(t1_collB[0]), CW'(1'b1));
    set_rd(0, 3); step(); drain();
    $display("reread b0 r3 -> %h coll=%b", dslice(0), t1_collB[0]);
    chk("reread_new", CW'(dslice(0)), CW'(W'(8'hAA)));
    chk("reread_nocoll", CW'(t1_collB[0]), CW'(1'b0));

    set_rd(1, NR); step(); drain();
    $display("rd b1 r%0d -> err=%b", NR, t1_errA);
    chk("oob_err", CW'(t1_errA), CW'(4'b1010));
    chk("oob_hold", CW'(dslice(1)), CW'(W'(4'hF)));

    for (int b = 0; b < NB; b++) set_wr(b, 10 + b, pat(b), ONES);
    step(); clear();
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < NB; b++) set_rd(b, 10 + b);
      step();
    end
    clear();
    $display("stream b2 -> %h before reset", dslice(2));
    chk("stream_b2", CW'(dslice(2)), CW'(W'(32'h0303_0303)));
    assert_rst();
    $display("reset mid-stream -> dout=%h", t1_doutB);
    chk("midrst_dout", t1_doutB, '0);
    chk("midrst_err", CW'(t1_errA), CW'(4'b0000));
    chk("midrst_ready", CW'(ready), CW'(1'b0));
    step(); step();
    rst = 1'b0;
    wait_ready(n);
    chk("reinit_len", CW'(n), CW'(NR));
    for (int i = 0; i < 6; i++) step();
    chk("no_stale", t1_doutB, '0);
    set_rd(0, 10); step(); drain();
    $display("rd b0 r10 after reinit -> %h", dslice(0));
    chk("reinit_val", CW'(dslice(0)), CW'(IV));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
